// File: rtl/operand_mux_pipe_pkg.sv
// Shared definitions for the operand selector pipeline: default operand width,
// the occupancy states of the output skid buffer, and the flat-bus slice helper.
`ifndef OPERAND_MUX_PIPE_PKG_SV
`define OPERAND_MUX_PIPE_PKG_SV

// Slice source k (each w bits wide) out of a flattened operand bus.
`define OP_SLICE(bus, k, w) bus[(k)*(w) +: (w)]

package operand_mux_pipe_pkg;

  // Default operand width for the register-file to ALU path.
  localparam int unsigned OPERAND_W = 16;

  // Occupancy of the main register plus skid entry.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing buffered
    ST_ONE   = 2'd1,  // main register valid
    ST_FULL  = 2'd2   // main and skid both valid
  } skid_state_e;

endpackage

`endif

// File: rtl/operand_mux_pipe_if.sv
// Request/response bundle between the register-file read side and the ALU
// operand latch. The slave modport is the selector pipeline itself.
interface operand_mux_pipe_if
  import operand_mux_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = OPERAND_W,
  parameter int unsigned NUM_IN = 8
);
  localparam int unsigned SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err;
  logic                    err_clr;

  modport slave (
    input  in_data, in_sel, in_valid, out_ready, err_clr,
    output in_ready, out_data, out_sel, out_valid, err
  );

  modport master (
    output in_data, in_sel, in_valid, out_ready, err_clr,
    input  in_ready, out_data, out_sel, out_valid, err
  );
endinterface

// File: rtl/operand_mux_pipe_skid_buffer.sv
// Two-entry registered pipeline stage (main register + skid entry) with a
// valid/ready handshake on both sides. The upstream ready is a flop, so there
// is no combinational path from downstream ready back to upstream ready.
// Generic payload width so it can be reused elsewhere in the datapath.
module skid_buffer
  import operand_mux_pipe_pkg::*;
#(
  parameter int unsigned W = 8
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_up_data,
  input  logic         i_up_valid,
  output logic         o_up_ready,
  output logic [W-1:0] o_dn_data,
  output logic         o_dn_valid,
  input  logic         i_dn_ready
);

  skid_state_e  r_state;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         r_main_valid;
  logic         r_up_ready;
  logic         w_accept;
  logic         w_emit;

  assign w_accept = i_up_valid & r_up_ready;
  assign w_emit   = r_main_valid & i_dn_ready;

  assign o_up_ready = r_up_ready;
  assign o_dn_data  = r_main;
  assign o_dn_valid = r_main_valid;

  // Occupancy FSM; the handshake flags are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_up_ready   <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main       <= i_up_data;
            r_main_valid <= 1'b1;
            r_state      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_emit) begin
            // Pass-through: replace the departing word, no bubble.
            r_main <= i_up_data;
          end else if (w_accept) begin
            // Main is stalled: park the new word in the skid entry.
            r_skid     <= i_up_data;
            r_up_ready <= 1'b0;
            r_state    <= ST_FULL;
          end else if (w_emit) begin
            r_main_valid <= 1'b0;
            r_state      <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Upstream is held off here, so only a drain can happen.
          if (w_emit) begin
            r_main     <= r_skid;
            r_up_ready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_state      <= ST_EMPTY;
          r_main_valid <= 1'b0;
          r_up_ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/operand_mux_pipe.sv
// N-way operand selector feeding a registered, flow-controlled output stage.
// The source mux and range check are combinational in front of the skid
// buffer; out-of-range selects produce a zero operand and set a sticky error.
module operand_mux_pipe
  import operand_mux_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = OPERAND_W,
  parameter int unsigned NUM_IN = 8
)(
  input logic               clk,
  input logic               rst_n,
  operand_mux_pipe_if.slave bus
);

  localparam int unsigned SEL_W = $clog2(NUM_IN);
  // The mux is padded to the full select range so any index is decodable;
  // padded slots read as zero and are marked out of range.
  localparam int unsigned SEL_N = 2 ** SEL_W;

  logic [WIDTH-1:0]       w_src [SEL_N];
  logic [SEL_N-1:0]       w_in_range;
  logic [WIDTH+SEL_W-1:0] w_up_payload;
  logic [WIDTH+SEL_W-1:0] w_dn_payload;
  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_bad_accept;
  logic                   r_err;

  generate
    for (genvar k = 0; k < SEL_N; k++) begin : g_src
      if (k < NUM_IN) begin : g_live
        assign w_src[k]      = `OP_SLICE(bus.in_data, k, WIDTH);
        assign w_in_range[k] = 1'b1;
      end else begin : g_pad
        assign w_src[k]      = '0;
        assign w_in_range[k] = 1'b0;
      end
    end
  endgenerate

  // Payload carries the operand together with the index that produced it.
  assign w_up_payload = {w_src[bus.in_sel], bus.in_sel};

  skid_buffer #(
    .W (WIDTH + SEL_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_up_data  (w_up_payload),
    .i_up_valid (bus.in_valid),
    .o_up_ready (w_in_ready),
    .o_dn_data  (w_dn_payload),
    .o_dn_valid (bus.out_valid),
    .i_dn_ready (bus.out_ready)
  );

  assign bus.in_ready = w_in_ready;
  assign bus.out_data = w_dn_payload[SEL_W +: WIDTH];
  assign bus.out_sel  = w_dn_payload[SEL_W-1:0];

  assign w_accept     = bus.in_valid & w_in_ready;
  assign w_bad_accept = w_accept & ~w_in_range[bus.in_sel];

  // Sticky range error; a new bad accept beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_bad_accept) begin
      r_err <= 1'b1;
    end else if (bus.err_clr) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err;
    end
  end

  assign bus.err = r_err;

endmodule

// File: tb/tb_operand_mux_pipe.sv
// Directed bench for operand_mux_pipe: an 8-source instance driven from a
// vector table (ordering, back-pressure, streaming) and a 5-source instance
// for the range-error rules, plus a mid-operation reset sequence.
module tb_operand_mux_pipe;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  operand_mux_pipe_if #(.WIDTH(16), .NUM_IN(8)) b8 ();
  operand_mux_pipe_if #(.WIDTH(16), .NUM_IN(5)) b5 ();

  operand_mux_pipe #(.WIDTH(16), .NUM_IN(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  operand_mux_pipe #(.WIDTH(16), .NUM_IN(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        vld;
    logic        rdy;
    logic [2:0]  sel;
    logic [15:0] val;
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_data;
    logic [2:0]  e_sel;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic vld, input logic rdy, input logic [2:0] sel,
                              input logic [15:0] val, input logic e_ir, input logic e_ov,
                              input logic [15:0] e_data, input logic [2:0] e_sel);
    vec_t v;
    v.vld = vld; v.rdy = rdy; v.sel = sel; v.val = val;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_data = e_data; v.e_sel = e_sel;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Selected source gets val; every other source gets a distinct filler.
  task automatic drive8(input logic vld, input logic [2:0] sel, input logic [15:0] val,
                        input logic rdy);
    for (int k = 0; k < 8; k++)
      b8.in_data[k*16 +: 16] = (k == int'(sel)) ? val : (16'hF000 | 16'(k));
    b8.in_sel    = sel;
    b8.in_valid  = vld;
    b8.out_ready = rdy;
  endtask

  task automatic drive5(input logic vld, input logic [2:0] sel, input logic [15:0] val,
                        input logic clr);
    for (int k = 0; k < 5; k++)
      b5.in_data[k*16 +: 16] = (k == int'(sel)) ? val : (16'hE000 | 16'(k));
    b5.in_sel    = sel;
    b5.in_valid  = vld;
    b5.out_ready = 1'b1;
    b5.err_clr   = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    drive8(1'b0, 3'd0, 16'h0000, 1'b1);
    b8.err_clr = 1'b0;
    drive5(1'b0, 3'd0, 16'h0000, 1'b0);

    // Asynchronous reset: outputs must settle before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst ov8",   32'(b8.out_valid), 32'd0);
    check("rst data8", 32'(b8.out_data),  32'd0);
    check("rst sel8",  32'(b8.out_sel),   32'd0);
    check("rst err8",  32'(b8.err),       32'd0);
    check("rst ir8",   32'(b8.in_ready),  32'd1);
    check("rst ov5",   32'(b5.out_valid), 32'd0);
    check("rst err5",  32'(b5.err),       32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Latency and ordering with out_ready high.
    vecs.push_back(mk(1'b1, 1'b1, 3'd3, 16'hBEEF, 1'b1, 1'b1, 16'hBEEF, 3'd3));
    vecs.push_back(mk(1'b1, 1'b1, 3'd0, 16'h1234, 1'b1, 1'b1, 16'h1234, 3'd0));
    vecs.push_back(mk(1'b0, 1'b1, 3'd0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0));
    // Back-pressure: A held in main, B into skid, C stalled until drain.
    vecs.push_back(mk(1'b1, 1'b0, 3'd1, 16'hAAAA, 1'b1, 1'b1, 16'hAAAA, 3'd1));
    vecs.push_back(mk(1'b1, 1'b0, 3'd2, 16'hBBBB, 1'b0, 1'b1, 16'hAAAA, 3'd1));
    vecs.push_back(mk(1'b1, 1'b0, 3'd5, 16'hCCCC, 1'b0, 1'b1, 16'hAAAA, 3'd1));
    vecs.push_back(mk(1'b1, 1'b1, 3'd5, 16'hCCCC, 1'b1, 1'b1, 16'hBBBB, 3'd2));
    vecs.push_back(mk(1'b1, 1'b1, 3'd5, 16'hCCCC, 1'b1, 1'b1, 16'hCCCC, 3'd5));
    vecs.push_back(mk(1'b0, 1'b1, 3'd0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0));
    // Streaming: one transfer per cycle, ready never drops.
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(1'b1, 1'b1, 3'(k % 8), 16'h5000 + 16'(k), 1'b1, 1'b1,
                        16'h5000 + 16'(k), 3'(k % 8)));
    vecs.push_back(mk(1'b0, 1'b1, 3'd0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0));

    foreach (vecs[i]) begin
      drive8(vecs[i].vld, vecs[i].sel, vecs[i].val, vecs[i].rdy);
      step();
      check($sformatf("vec%0d in_ready", i),  32'(b8.in_ready),  32'(vecs[i].e_ir));
      check($sformatf("vec%0d out_valid", i), 32'(b8.out_valid), 32'(vecs[i].e_ov));
      if (vecs[i].e_ov) begin
        check($sformatf("vec%0d out_data", i), 32'(b8.out_data), 32'(vecs[i].e_data));
        check($sformatf("vec%0d out_sel", i),  32'(b8.out_sel),  32'(vecs[i].e_sel));
      end
    end
    check("err8 stays clear", 32'(b8.err), 32'd0);

    // Range check on the 5-source instance.
    drive5(1'b1, 3'd6, 16'h6666, 1'b0);
    step();
    check("bad6 out_valid", 32'(b5.out_valid), 32'd1);
    check("bad6 out_data",  32'(b5.out_data),  32'd0);
    check("bad6 out_sel",   32'(b5.out_sel),   32'd6);
    check("bad6 err",       32'(b5.err),       32'd1);
    drive5(1'b1, 3'd7, 16'h7777, 1'b1);
    step();
    check("bad7+clr err",      32'(b5.err),      32'd1);
    check("bad7 out_data",     32'(b5.out_data), 32'd0);
    check("bad7 out_sel",      32'(b5.out_sel),  32'd7);
    drive5(1'b0, 3'd0, 16'h0000, 1'b1);
    step();
    check("clean clr err",     32'(b5.err),       32'd0);
    check("clean clr ov",      32'(b5.out_valid), 32'd0);
    drive5(1'b1, 3'd4, 16'h4444, 1'b0);
    step();
    check("last src out_data", 32'(b5.out_data), 32'h4444);
    check("last src out_sel",  32'(b5.out_sel),  32'd4);
    check("last src err",      32'(b5.err),      32'd0);
    drive5(1'b0, 3'd0, 16'h0000, 1'b0);
    step();
    check("idle5 out_valid",   32'(b5.out_valid), 32'd0);

    // Fill main and skid, then reset in the middle of a cycle.
    drive8(1'b1, 3'd1, 16'hAAA1, 1'b0);
    step();
    drive8(1'b1, 3'd2, 16'hAAA2, 1'b0);
    step();
    check("full in_ready", 32'(b8.in_ready), 32'd0);
    check("full out_data", 32'(b8.out_data), 32'hAAA1);
    drive8(1'b0, 3'd0, 16'h0000, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(b8.out_valid), 32'd0);
    check("midrst in_ready",  32'(b8.in_ready),  32'd1);
    check("midrst out_data",  32'(b8.out_data),  32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive8(1'b0, 3'd0, 16'h0000, 1'b1);
    step();
    check("postrst empty ov", 32'(b8.out_valid), 32'd0);
    drive8(1'b1, 3'd7, 16'h7777, 1'b1);
    step();
    check("postrst out_valid", 32'(b8.out_valid), 32'd1);
    check("postrst out_data",  32'(b8.out_data),  32'h7777);
    check("postrst out_sel",   32'(b8.out_sel),   32'd7);
    drive8(1'b0, 3'd0, 16'h0000, 1'b1);
    step();
    check("postrst drain ov",  32'(b8.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
